// File: rtl/irq_trap_arbiter.sv
// Interrupt arbiter: samples level IRQ lines, applies enable/delegation/privilege
// rules and RISC-V priority, and presents a latched trap request. Optional macro IRQ_SYNC_EN.
module irq_trap_arbiter #(
  parameter int NUM_IRQ     = 12,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic [NUM_IRQ-1:0] irq_enable,
  input  logic [NUM_IRQ-1:0] mideleg,
  input  logic               global_mie,
  input  logic               global_sie,
  input  logic [1:0]         privilege_mode,
  input  logic               instr_boundary,
  input  logic               trap_ack,
  input  logic               wfi_active,
  output logic [NUM_IRQ-1:0] pending,
  output logic               trap_req,
  output logic [31:0]        trap_cause,
  output logic               trap_to_s,
  output logic               wfi_wake
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    HOLDOFF
  } state_t;

  localparam logic [1:0] PrivU = 2'd0;
  localparam logic [1:0] PrivS = 2'd1;
  localparam logic [1:0] PrivM = 2'd3;

  state_t             state_q, state_d;
  logic               load_winner;
  logic [NUM_IRQ-1:0] irq_sampled;
  logic [NUM_IRQ-1:0] pending_q;
  logic [31:0]        trap_cause_q;
  logic               trap_to_s_q;
  logic               wfi_wake_q;

  logic               m_target_en, s_target_en;
  logic [NUM_IRQ-1:0] elig_m, elig_s;
  logic [5:0]         win_m, win_s;
  logic               any_elig;
  logic [4:0]         win_idx;
  logic               win_to_s;

`ifdef IRQ_SYNC_EN
  logic [NUM_IRQ-1:0] sync_q [SYNC_STAGES];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= irq_in;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign irq_sampled = sync_q[SYNC_STAGES-1];
`else
  assign irq_sampled = irq_in;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pending_q  <= '0;
      wfi_wake_q <= 1'b0;
    end else begin
      pending_q  <= irq_sampled;
      wfi_wake_q <= wfi_active & (|(pending_q & irq_enable));
    end
  end

  // Shift-based bit pick keeps out-of-range fixed indices (e.g. 11 with 6 lines) harmless.
  function automatic logic bit_at(input logic [NUM_IRQ-1:0] v, input int idx);
    return 1'(v >> idx);
  endfunction

  function automatic int fixed_prio(input int rank);
    case (rank)
      0:       return 11;
      1:       return 3;
      2:       return 7;
      3:       return 9;
      4:       return 1;
      default: return 5;
    endcase
  endfunction

  function automatic logic is_fixed(input int idx);
    return (idx == 11) || (idx == 3) || (idx == 7) || (idx == 9) || (idx == 1) || (idx == 5);
  endfunction

  // Returns {found, index}; later assignments override earlier ones, so scan lowest priority first.
  function automatic logic [5:0] pick_winner(input logic [NUM_IRQ-1:0] v);
    logic [5:0] r;
    r = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (!is_fixed(i) && bit_at(v, i)) r = {1'b1, 5'(i)};
    end
    for (int k = 5; k >= 0; k--) begin
      if (bit_at(v, fixed_prio(k))) r = {1'b1, 5'(fixed_prio(k))};
    end
    return r;
  endfunction

  always_comb begin
    m_target_en = (privilege_mode != PrivM) || global_mie;
    s_target_en = (privilege_mode == PrivU) || ((privilege_mode == PrivS) && global_sie);
    elig_m      = pending_q & irq_enable & ~mideleg & {NUM_IRQ{m_target_en}};
    elig_s      = pending_q & irq_enable & mideleg & {NUM_IRQ{s_target_en}};
    win_m       = pick_winner(elig_m);
    win_s       = pick_winner(elig_s);
    any_elig    = win_m[5] | win_s[5];
    win_idx     = win_m[5] ? win_m[4:0] : win_s[4:0];
    win_to_s    = ~win_m[5];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // trap_ack only matters in REQ and takes precedence over a fresh boundary.
  always_comb begin
    state_d     = state_q;
    load_winner = 1'b0;
    case (state_q)
      IDLE: begin
        if (instr_boundary && any_elig) begin
          state_d     = REQ;
          load_winner = 1'b1;
        end
      end
      REQ: begin
        if (trap_ack) state_d = HOLDOFF;
      end
      HOLDOFF: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      trap_cause_q <= '0;
      trap_to_s_q  <= 1'b0;
    end else if (load_winner) begin
      trap_cause_q <= {1'b1, 31'(win_idx)};
      trap_to_s_q  <= win_to_s;
    end
  end

  assign pending    = pending_q;
  assign trap_req   = (state_q == REQ);
  assign trap_cause = trap_cause_q;
  assign trap_to_s  = trap_to_s_q;
  assign wfi_wake   = wfi_wake_q;

endmodule
